// File: rtl/score_bcd_counter.sv
// Packed-BCD game score counter with frame-tick divider, bonus add and wrap/saturate.
// Ports: clk, rst_n, game_start/over/tick, bonus_valid/val in; score, high_score, new_high, active, overflow out.
// Optional: define SCORE_HIGH_SCORE_EN to track the session high score.
module score_bcd_counter #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 1,
  parameter int WRAP     = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  game_start,
  input  logic                  game_over,
  input  logic                  game_tick,
  input  logic                  bonus_valid,
  input  logic [3:0]            bonus_val,
  output logic [4*DIGITS-1:0]   score,
  output logic [4*DIGITS-1:0]   high_score,
  output logic                  new_high,
  output logic                  active,
  output logic                  overflow
);

  localparam int              W       = 4 * DIGITS;
  localparam logic [7:0]      DIV_MAX = 8'(TICK_DIV - 1);
  localparam logic [W-1:0]    ALL9    = {DIGITS{4'h9}};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    OVER
  } state_t;

  state_t         state_q;
  logic [W-1:0]   score_q;
  logic [W-1:0]   sum_d;
  logic [W-1:0]   score_d;
  logic [7:0]     div_q;
  logic           ovf_q;
  logic           point_inc;
  logic           cout_d;
  logic [3:0]     bonus_eff;
  logic [3:0]     delta;
  logic [3:0]     cy;
  logic [4:0]     dsum;

  assign point_inc = game_tick && (div_q == DIV_MAX);
  assign bonus_eff = (bonus_val > 4'd9) ? 4'd9 : bonus_val;
  assign delta     = {3'b000, point_inc}
                   + (bonus_valid ? bonus_eff : 4'd0);

  // Delta (0..10) enters digit 0; after that only a 0/1 carry ripples.
  // Subtracting 10 in 4-bit arithmetic also fixes sums 16..19.
  always_comb begin
    sum_d = score_q;
    cy    = delta;
    dsum  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dsum = {1'b0, score_q[4*i+:4]} + {1'b0, cy};
      if (dsum > 5'd9) begin
        sum_d[4*i+:4] = dsum[3:0] - 4'd10;
        cy            = 4'd1;
      end else begin
        sum_d[4*i+:4] = dsum[3:0];
        cy            = 4'd0;
      end
    end
    cout_d  = cy[0];
    score_d = (cout_d && (WRAP == 0)) ? ALL9 : sum_d;
  end

`ifdef SCORE_HIGH_SCORE_EN
  logic [W-1:0] hs_q;
  logic         nh_q;
  assign high_score = hs_q;
  assign new_high   = nh_q;
`else
  assign high_score = '0;
  assign new_high   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      score_q <= '0;
      div_q   <= '0;
      ovf_q   <= 1'b0;
`ifdef SCORE_HIGH_SCORE_EN
      hs_q    <= '0;
      nh_q    <= 1'b0;
`endif
    end else begin
`ifdef SCORE_HIGH_SCORE_EN
      nh_q <= 1'b0;
`endif
      if (game_start) begin
        state_q <= RUN;
        score_q <= '0;
        div_q   <= '0;
        ovf_q   <= 1'b0;
      end else if (state_q == RUN) begin
        if (game_tick) begin
          div_q <= point_inc ? 8'd0 : div_q + 8'd1;
        end
        score_q <= score_d;
        if (cout_d) begin
          ovf_q <= 1'b1;
        end
        if (game_over) begin
          state_q <= OVER;
`ifdef SCORE_HIGH_SCORE_EN
          // Valid packed BCD orders like binary: MSD-first compare.
          if (score_d > hs_q) begin
            hs_q <= score_d;
            nh_q <= 1'b1;
          end
`endif
        end
      end
    end
  end

  assign score    = score_q;
  assign active   = (state_q == RUN);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_score_bcd_counter.sv
// Bench for score_bcd_counter: three instances (default, TICK_DIV=3, WRAP=1)
// checked against a decimal integer model through an expect/observe scoreboard.
module tb_score_bcd_counter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic gs = 1'b0;
  logic go = 1'b0;
  logic gt = 1'b0;
  logic bvld = 1'b0;
  logic [3:0] bv = 4'd0;

  always #5 clk = ~clk;

  logic [15:0] sc0, hs0, sc3, hs3, scw, hsw;
  logic nh0, act0, ov0, nh3, act3, ov3, nhw, actw, ovw;

  score_bcd_counter u0 (
    .clk(clk), .rst_n(rst_n), .game_start(gs), .game_over(go),
    .game_tick(gt), .bonus_valid(bvld), .bonus_val(bv),
    .score(sc0), .high_score(hs0), .new_high(nh0),
    .active(act0), .overflow(ov0)
  );

  score_bcd_counter #(.TICK_DIV(3)) u3 (
    .clk(clk), .rst_n(rst_n), .game_start(gs), .game_over(go),
    .game_tick(gt), .bonus_valid(bvld), .bonus_val(bv),
    .score(sc3), .high_score(hs3), .new_high(nh3),
    .active(act3), .overflow(ov3)
  );

  score_bcd_counter #(.WRAP(1)) uw (
    .clk(clk), .rst_n(rst_n), .game_start(gs), .game_over(go),
    .game_tick(gt), .bonus_valid(bvld), .bonus_val(bv),
    .score(scw), .high_score(hsw), .new_high(nhw),
    .active(actw), .overflow(ovw)
  );

  typedef struct packed {
    logic [15:0] sc;
    logic [15:0] hs;
    logic        act;
    logic        nh;
    logic        ov;
  } obs_t;

  obs_t expq[$];
  obs_t obsq[$];
  int passed = 0;
  int total = 0;

`ifdef SCORE_HIGH_SCORE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  int m_st[3];
  int m_sc[3];
  int m_dv[3];
  int m_hs[3];
  bit m_ov[3];
  bit m_nh[3];

  function automatic int div_of(int k);
    return (k == 1) ? 3 : 1;
  endfunction

  function automatic logic [15:0] to_bcd(int x);
    logic [15:0] r;
    int v;
    v = x;
    r = '0;
    for (int d = 0; d < 4; d++) begin
      r[4*d+:4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_st[k] = 0; m_sc[k] = 0; m_dv[k] = 0;
      m_hs[k] = 0; m_ov[k] = 0; m_nh[k] = 0;
    end
  endtask

  task automatic model_step(input bit s, input bit o, input bit t,
                            input int b, input bit bval);
    int pi;
    int n;
    for (int k = 0; k < 3; k++) begin
      m_nh[k] = 0;
      if (s) begin
        m_st[k] = 1; m_sc[k] = 0; m_dv[k] = 0; m_ov[k] = 0;
      end else if (m_st[k] == 1) begin
        pi = 0;
        if (t) begin
          if (m_dv[k] == div_of(k) - 1) begin
            pi = 1; m_dv[k] = 0;
          end else begin
            m_dv[k]++;
          end
        end
        n = m_sc[k] + pi + (bval ? ((b > 9) ? 9 : b) : 0);
        if (n > 9999) begin
          m_ov[k] = 1;
          m_sc[k] = (k == 2) ? n - 10000 : 9999;
        end else begin
          m_sc[k] = n;
        end
        if (o) begin
          m_st[k] = 2;
          if (HS && m_sc[k] > m_hs[k]) begin
            m_hs[k] = m_sc[k]; m_nh[k] = 1;
          end
        end
      end
    end
  endtask

  function automatic obs_t exp_of(int k);
    obs_t e;
    e.sc = to_bcd(m_sc[k]);
    e.hs = to_bcd(m_hs[k]);
    e.act = (m_st[k] == 1);
    e.nh = m_nh[k];
    e.ov = m_ov[k];
    return e;
  endfunction

  function automatic obs_t obs_of(int k);
    obs_t g;
    case (k)
      0: g = '{sc0, hs0, act0, nh0, ov0};
      1: g = '{sc3, hs3, act3, nh3, ov3};
      default: g = '{scw, hsw, actw, nhw, ovw};
    endcase
    return g;
  endfunction

  task automatic push_exp();
    for (int k = 0; k < 3; k++) expq.push_back(exp_of(k));
  endtask

  task automatic push_obs();
    for (int k = 0; k < 3; k++) obsq.push_back(obs_of(k));
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic step(input bit s, input bit o, input bit t,
                      input int b, input bit bval, input bit chk);
    gs = s; go = o; gt = t; bv = 4'(b); bvld = bval;
    model_step(s, o, t, b, bval);
    if (chk) push_exp();
    @(posedge clk);
    #1;
    gs = 0; go = 0; gt = 0; bv = 4'd0; bvld = 0;
    if (chk) push_obs();
  endtask

  task automatic test_reset();
    model_reset();
    #2;
    push_exp();
    push_obs();
    #6 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(0, 0, 0, 0, 0, 1);
    while (expq.size() > 0) begin
      obs_t e, g;
      e = expq.pop_front(); g = obsq.pop_front(); total++;
      if (g !== e) $display("FAIL reset: got %h want %h", g, e);
      else passed++;
    end
  endtask

  task automatic test_idle_ticks();
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, i == 2);
    step(0, 1, 1, 5, 1, 1);
    while (expq.size() > 0) begin
      obs_t e, g;
      e = expq.pop_front(); g = obsq.pop_front(); total++;
      if (g !== e) $display("FAIL idle_ticks: got %h want %h", g, e);
      else passed++;
    end
  endtask

  task automatic test_tick_count();
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 12; i++) step(0, 0, 1, 0, 0, i == 11);
    total++;
    if (sc0 !== 16'h0012 || act0 !== 1'b1)
      $display("FAIL tick12: got %h/%b want 0012/1", sc0, act0);
    else passed++;
    while (expq.size() > 0) begin
      obs_t e, g;
      e = expq.pop_front(); g = obsq.pop_front(); total++;
      if (g !== e) $display("FAIL tick_count: got %h want %h", g, e);
      else passed++;
    end
  endtask

  task automatic test_tick_div();
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 0, 1);
    total++;
    if (sc3 !== 16'h0002)
      $display("FAIL div3: got %h want 0002", sc3);
    else passed++;
    while (expq.size() > 0) begin
      obs_t e, g;
      e = expq.pop_front(); g = obsq.pop_front(); total++;
      if (g !== e) $display("FAIL tick_div: got %h want %h", g, e);
      else passed++;
    end
  endtask

  task automatic test_bonus_carry();
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 9, 1, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0, i == 7);
    step(0, 0, 1, 9, 1, 1);
    total++;
    if (sc0 !== 16'h0108)
      $display("FAIL carry108: got %h want 0108", sc0);
    else passed++;
    step(0, 0, 0, 15, 1, 1);
    total++;
    if (sc0 !== 16'h0117)
      $display("FAIL clamp15: got %h want 0117", sc0);
    else passed++;
    step(0, 0, 0, 7, 0, 1);
    while (expq.size() > 0) begin
      obs_t e, g;
      e = expq.pop_front(); g = obsq.pop_front(); total++;
      if (g !== e) $display("FAIL bonus_carry: got %h want %h", g, e);
      else passed++;
    end
  endtask

  task automatic test_high_score();
    for (int gm = 0; gm < 2; gm++) begin
      step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 42; i++) step(0, 0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
    end
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 11; i++) step(0, 0, 0, 9, 1, 0);
    step(0, 1, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 9, 1, 1);
    step(0, 1, 0, 0, 0, 1);
    while (expq.size() > 0) begin
      obs_t e, g;
      e = expq.pop_front(); g = obsq.pop_front(); total++;
      if (g !== e) $display("FAIL high_score: got %h want %h", g, e);
      else passed++;
    end
  endtask

  task automatic test_start_over_same();
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 0);
    step(1, 1, 1, 9, 1, 1);
    total++;
    if (sc0 !== 16'h0000 || act0 !== 1'b1)
      $display("FAIL start_wins: got %h/%b want 0000/1", sc0, act0);
    else passed++;
    step(0, 0, 1, 0, 0, 1);
    while (expq.size() > 0) begin
      obs_t e, g;
      e = expq.pop_front(); g = obsq.pop_front(); total++;
      if (g !== e) $display("FAIL start_over: got %h want %h", g, e);
      else passed++;
    end
  endtask

  task automatic test_saturate();
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 1110; i++) step(0, 0, 0, 9, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, i == 4);
    step(0, 0, 0, 9, 1, 1);
    total++;
    if (sc0 !== 16'h9999 || ov0 !== 1'b1 || scw !== 16'h0004 || ovw !== 1'b1)
      $display("FAIL sat_wrap: got %h/%b %h/%b want 9999/1 0004/1",
               sc0, ov0, scw, ovw);
    else passed++;
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 3, 1, 1);
    while (expq.size() > 0) begin
      obs_t e, g;
      e = expq.pop_front(); g = obsq.pop_front(); total++;
      if (g !== e) $display("FAIL saturate: got %h want %h", g, e);
      else passed++;
    end
  endtask

  task automatic test_async_reset();
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 2, 1, 0);
    step(0, 0, 1, 0, 0, 1);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    push_exp();
    push_obs();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(0, 0, 1, 0, 0, 1);
    while (expq.size() > 0) begin
      obs_t e, g;
      e = expq.pop_front(); g = obsq.pop_front(); total++;
      if (g !== e) $display("FAIL async_reset: got %h want %h", g, e);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_idle_ticks();
    test_tick_count();
    test_tick_div();
    test_bonus_carry();
    test_high_score();
    test_start_over_same();
    test_saturate();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
